pipe_ctrl: RTL and testbench

- Central stall/flush controller for the in-order pipeline.
- Arbitrates redirect sources (trap, mret, branch) and hazard stalls (load-use, multi-cycle unit busy).
- Drives the PC register's stall/flush/flush-PC inputs and the IF/ID and ID/EX stage enables/bubbles.
- Sequences trap entry through a small FSM that commits mepc/mcause to the CSR file before redirecting to mtvec.

---
 rtl/pipe_ctrl_pkg.sv | 19 +
 rtl/pipe_ctrl_if.sv | 55 +++++
 rtl/dff_sr.sv | 20 ++
 rtl/pipe_ctrl_perf_cnt.sv | 17 +
 rtl/pipe_ctrl.sv | 142 ++++++++++++++
 tb/tb_pipe_ctrl.sv | 353 +++++++++++++++++++++++++++++++++++
 6 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline stall/flush controller: trap FSM state
// encodings and the default PC / cause widths (PC width follows `PC_WIDTH).
`ifndef PC_WIDTH
`define PC_WIDTH 32
`endif

package pipe_ctrl_pkg;

    localparam int DEF_PC_W    = `PC_WIDTH;
    localparam int DEF_CAUSE_W = 5;

    typedef enum logic [1:0] {
        PIPE_CTRL_IDLE = 2'd0,
        TRAP_WAIT      = 2'd1,
        TRAP_COMMIT    = 2'd2,
        TRAP_REDIR     = 2'd3
    } state_t;

endpackage

// File: rtl/pipe_ctrl_if.sv
// Hazard/redirect request and stall/flush control bundle for pipe_ctrl.
// The perf counter signals exist only when PIPE_CTRL_PERF_EN is defined.
interface pipe_ctrl_if
    import pipe_ctrl_pkg::*;
#(
    parameter int PC_W    = DEF_PC_W,
    parameter int CAUSE_W = DEF_CAUSE_W
);
    logic               br_taken;
    logic [PC_W-1:0]    br_target;
    logic               mret;
    logic [PC_W-1:0]    mepc;
    logic [PC_W-1:0]    mtvec;
    logic               trap;
    logic [CAUSE_W-1:0] trap_cause;
    logic [PC_W-1:0]    trap_pc;
    logic               ld_use;
    logic               mdu_busy;

    logic               stall_pc;
    logic               stall_if_id;
    logic               stall_id_ex;
    logic               bubble_id_ex;
    logic               flush;
    logic [PC_W-1:0]    flush_pc;
    logic               csr_trap_we;
    logic [PC_W-1:0]    csr_epc;
    logic [CAUSE_W-1:0] csr_cause;
`ifdef PIPE_CTRL_PERF_EN
    logic [31:0]        perf_stall_cnt;
    logic [31:0]        perf_flush_cnt;
`endif

    // The pipeline raises requests; the controller answers with stall/flush.
    modport master (
        output br_taken, br_target, mret, mepc, mtvec, trap, trap_cause, trap_pc,
               ld_use, mdu_busy,
        input  stall_pc, stall_if_id, stall_id_ex, bubble_id_ex, flush, flush_pc,
               csr_trap_we, csr_epc, csr_cause
`ifdef PIPE_CTRL_PERF_EN
        , input perf_stall_cnt, perf_flush_cnt
`endif
    );

    modport slave (
        input  br_taken, br_target, mret, mepc, mtvec, trap, trap_cause, trap_pc,
               ld_use, mdu_busy,
        output stall_pc, stall_if_id, stall_id_ex, bubble_id_ex, flush, flush_pc,
               csr_trap_we, csr_epc, csr_cause
`ifdef PIPE_CTRL_PERF_EN
        , output perf_stall_cnt, perf_flush_cnt
`endif
    );

endinterface

// File: rtl/dff_sr.sv
// Generic register cell with load enable and synchronous active-high reset to zero.
module dff_sr #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    always_ff @(posedge clk) begin
        if (rst) begin
            q <= '0;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/pipe_ctrl_perf_cnt.sv
// 32-bit event counter that sticks at all-ones instead of wrapping.
module pipe_ctrl_perf_cnt (
    input  logic        clk,
    input  logic        rst,
    input  logic        inc,
    output logic [31:0] cnt
);

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (inc && (cnt != 32'hFFFF_FFFF)) begin
            cnt <= cnt + 32'd1;
        end
    end

endmodule

// File: rtl/pipe_ctrl.sv
// Central stall/flush controller: arbitrates trap > mret > branch > mdu busy > load-use
// and sequences trap entry (wait, CSR commit, redirect). PIPE_CTRL_PERF_EN adds perf counters.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int PC_W    = DEF_PC_W,
    parameter int CAUSE_W = DEF_CAUSE_W
) (
    input logic        clk,
    input logic        rst,
    pipe_ctrl_if.slave pif
);

    state_t             state;
    state_t             state_next;
    logic [1:0]         state_raw;
    logic [PC_W-1:0]    epc_q;
    logic [CAUSE_W-1:0] cause_q;
    logic               latch_trap;

    logic               stall_pc;
    logic               stall_if_id;
    logic               stall_id_ex;
    logic               bubble_id_ex;
    logic               flush;
    logic [PC_W-1:0]    flush_pc;
    logic               csr_trap_we;
    logic [PC_W-1:0]    csr_epc;
    logic [CAUSE_W-1:0] csr_cause;

    dff_sr #(.W(2)) u_state (
        .clk(clk), .rst(rst), .en(1'b1), .d(state_next), .q(state_raw)
    );
    assign state = state_t'(state_raw);

    dff_sr #(.W(PC_W)) u_epc (
        .clk(clk), .rst(rst), .en(latch_trap), .d(pif.trap_pc), .q(epc_q)
    );

    dff_sr #(.W(CAUSE_W)) u_cause (
        .clk(clk), .rst(rst), .en(latch_trap), .d(pif.trap_cause), .q(cause_q)
    );

    // Flush never coexists with a stall: the PC register only loads when unstalled.
    always_comb begin
        state_next   = state;
        latch_trap   = 1'b0;
        stall_pc     = 1'b0;
        stall_if_id  = 1'b0;
        stall_id_ex  = 1'b0;
        bubble_id_ex = 1'b0;
        flush        = 1'b0;
        flush_pc     = '0;
        csr_trap_we  = 1'b0;
        csr_epc      = '0;
        csr_cause    = '0;

        case (state)
            PIPE_CTRL_IDLE: begin
                if (pif.trap) begin
                    latch_trap  = 1'b1;
                    stall_pc    = 1'b1;
                    stall_if_id = 1'b1;
                    stall_id_ex = 1'b1;
                    state_next  = pif.mdu_busy ? TRAP_WAIT : TRAP_COMMIT;
                end else if (pif.mret) begin
                    flush    = 1'b1;
                    flush_pc = pif.mepc;
                end else if (pif.br_taken) begin
                    flush    = 1'b1;
                    flush_pc = pif.br_target;
                end else if (pif.mdu_busy) begin
                    stall_pc    = 1'b1;
                    stall_if_id = 1'b1;
                    stall_id_ex = 1'b1;
                end else if (pif.ld_use) begin
                    stall_pc     = 1'b1;
                    stall_if_id  = 1'b1;
                    bubble_id_ex = 1'b1;
                end
            end
            TRAP_WAIT: begin
                stall_pc    = 1'b1;
                stall_if_id = 1'b1;
                stall_id_ex = 1'b1;
                if (!pif.mdu_busy) begin
                    state_next = TRAP_COMMIT;
                end
            end
            TRAP_COMMIT: begin
                stall_pc    = 1'b1;
                stall_if_id = 1'b1;
                stall_id_ex = 1'b1;
                csr_trap_we = 1'b1;
                csr_epc     = epc_q;
                csr_cause   = cause_q;
                state_next  = TRAP_REDIR;
            end
            TRAP_REDIR: begin
                flush      = 1'b1;
                flush_pc   = pif.mtvec;
                state_next = PIPE_CTRL_IDLE;
            end
            default: begin
                state_next = PIPE_CTRL_IDLE;
            end
        endcase

        if (rst) begin
            stall_pc     = 1'b0;
            stall_if_id  = 1'b0;
            stall_id_ex  = 1'b0;
            bubble_id_ex = 1'b0;
            flush        = 1'b0;
            flush_pc     = '0;
            csr_trap_we  = 1'b0;
            csr_epc      = '0;
            csr_cause    = '0;
        end
    end

    assign pif.stall_pc     = stall_pc;
    assign pif.stall_if_id  = stall_if_id;
    assign pif.stall_id_ex  = stall_id_ex;
    assign pif.bubble_id_ex = bubble_id_ex;
    assign pif.flush        = flush;
    assign pif.flush_pc     = flush_pc;
    assign pif.csr_trap_we  = csr_trap_we;
    assign pif.csr_epc      = csr_epc;
    assign pif.csr_cause    = csr_cause;

`ifdef PIPE_CTRL_PERF_EN
    pipe_ctrl_perf_cnt u_stall_cnt (
        .clk(clk), .rst(rst), .inc(stall_pc), .cnt(pif.perf_stall_cnt)
    );

    pipe_ctrl_perf_cnt u_flush_cnt (
        .clk(clk), .rst(rst), .inc(flush), .cnt(pif.perf_flush_cnt)
    );
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: directed scenarios plus a randomized run
// compared against a cycle-schedule model of the stall/flush/trap rules.
module tb_pipe_ctrl;
    import pipe_ctrl_pkg::*;

    localparam int PW    = DEF_PC_W;
    localparam int CW    = DEF_CAUSE_W;
    localparam int OW    = 4 + 1 + PW + 1 + PW + CW;
    localparam int NRAND = 400;

    localparam logic [3:0] S_NONE  = 4'b0000;
    localparam logic [3:0] S_ALL   = 4'b1110;
    localparam logic [3:0] S_LDUSE = 4'b1101;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   passed = 0;

    pipe_ctrl_if #(.PC_W(PW), .CAUSE_W(CW)) pif ();

    pipe_ctrl #(.PC_W(PW), .CAUSE_W(CW)) dut (
        .clk(clk),
        .rst(rst),
        .pif(pif)
    );

    always #5 clk = ~clk;

    logic [OW-1:0] obs;
    logic [OW-1:0] exp_v;
    assign obs = {pif.stall_pc, pif.stall_if_id, pif.stall_id_ex, pif.bubble_id_ex,
                  pif.flush, pif.flush_pc, pif.csr_trap_we, pif.csr_epc, pif.csr_cause};

    logic            r_rst   [NRAND];
    logic            r_trap  [NRAND];
    logic            r_mret  [NRAND];
    logic            r_br    [NRAND];
    logic            r_busy  [NRAND];
    logic            r_ld    [NRAND];
    logic [PW-1:0]   r_tgt   [NRAND];
    logic [PW-1:0]   r_mepc  [NRAND];
    logic [PW-1:0]   r_mtvec [NRAND];
    logic [PW-1:0]   r_tpc   [NRAND];
    logic [CW-1:0]   r_cause [NRAND];
    logic [OW-1:0]   r_exp   [NRAND];

    // Output order: {stall_pc, stall_if_id, stall_id_ex, bubble}, flush, flush_pc, we, epc, cause.
    function automatic logic [OW-1:0] pack(input logic [3:0] stalls, input logic fl,
                                           input logic [PW-1:0] fpc, input logic we,
                                           input logic [PW-1:0] epc, input logic [CW-1:0] cause);
        return {stalls, fl, fpc, we, epc, cause};
    endfunction

    task automatic clear_in();
        pif.br_taken   = 1'b0;
        pif.br_target  = '0;
        pif.mret       = 1'b0;
        pif.mepc       = '0;
        pif.mtvec      = '0;
        pif.trap       = 1'b0;
        pif.trap_cause = '0;
        pif.trap_pc    = '0;
        pif.ld_use     = 1'b0;
        pif.mdu_busy   = 1'b0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        clear_in();
        pif.br_taken  = 1'b1;
        pif.br_target = 32'h0000_0100;
        next_cycle();
        @(negedge clk);
        checks++; exp_v = pack(S_NONE, 1'b0, '0, 1'b0, '0, '0);
        if (obs !== exp_v) $display("[TB] FAIL reset_outputs: got %h expected %h", obs, exp_v);
        else passed++;
        next_cycle();
        rst = 1'b0;
        @(negedge clk);
        checks++; exp_v = pack(S_NONE, 1'b1, 32'h0000_0100, 1'b0, '0, '0);
        if (obs !== exp_v) $display("[TB] FAIL reset_release_branch: got %h expected %h", obs, exp_v);
        else passed++;
        next_cycle();
        clear_in();
    endtask

    task automatic test_ld_use();
        pif.ld_use = 1'b1;
        @(negedge clk);
        checks++; exp_v = pack(S_LDUSE, 1'b0, '0, 1'b0, '0, '0);
        if (obs !== exp_v) $display("[TB] FAIL ld_use_stall: got %h expected %h", obs, exp_v);
        else passed++;
        next_cycle();
        pif.br_taken  = 1'b1;
        pif.br_target = 32'h0000_0200;
        @(negedge clk);
        checks++; exp_v = pack(S_NONE, 1'b1, 32'h0000_0200, 1'b0, '0, '0);
        if (obs !== exp_v) $display("[TB] FAIL ld_use_with_branch: got %h expected %h", obs, exp_v);
        else passed++;
        next_cycle();
        clear_in();
    endtask

    task automatic test_trap_idle();
        pif.trap       = 1'b1;
        pif.trap_cause = 5'd2;
        pif.trap_pc    = 32'h8000_0040;
        pif.mtvec      = 32'h8000_0000;
        pif.br_taken   = 1'b1;
        pif.br_target  = 32'h0000_0300;
        @(negedge clk);
        checks++; exp_v = pack(S_ALL, 1'b0, '0, 1'b0, '0, '0);
        if (obs !== exp_v) $display("[TB] FAIL trap_entry: got %h expected %h", obs, exp_v);
        else passed++;
        next_cycle();
        clear_in();
        pif.mtvec = 32'h8000_0000;
        @(negedge clk);
        checks++; exp_v = pack(S_ALL, 1'b0, '0, 1'b1, 32'h8000_0040, 5'd2);
        if (obs !== exp_v) $display("[TB] FAIL trap_commit: got %h expected %h", obs, exp_v);
        else passed++;
        next_cycle();
        @(negedge clk);
        checks++; exp_v = pack(S_NONE, 1'b1, 32'h8000_0000, 1'b0, '0, '0);
        if (obs !== exp_v) $display("[TB] FAIL trap_redirect: got %h expected %h", obs, exp_v);
        else passed++;
        next_cycle();
        @(negedge clk);
        checks++; exp_v = pack(S_NONE, 1'b0, '0, 1'b0, '0, '0);
        if (obs !== exp_v) $display("[TB] FAIL trap_back_idle: got %h expected %h", obs, exp_v);
        else passed++;
        next_cycle();
        clear_in();
    endtask

    task automatic test_trap_busy();
        pif.trap       = 1'b1;
        pif.trap_cause = 5'd7;
        pif.trap_pc    = 32'h1000_0010;
        pif.mdu_busy   = 1'b1;
        @(negedge clk);
        checks++; exp_v = pack(S_ALL, 1'b0, '0, 1'b0, '0, '0);
        if (obs !== exp_v) $display("[TB] FAIL busy_trap_entry: got %h expected %h", obs, exp_v);
        else passed++;
        next_cycle();
        pif.trap = 1'b0;
        for (int i = 0; i < 3; i++) begin
            pif.mdu_busy  = (i < 2);
            pif.br_taken  = (i != 1);
            pif.br_target = 32'h0000_0444;
            pif.trap      = (i == 1);
            @(negedge clk);
            checks++; exp_v = pack(S_ALL, 1'b0, '0, 1'b0, '0, '0);
            if (obs !== exp_v) $display("[TB] FAIL busy_wait_%0d: got %h expected %h", i, obs, exp_v);
            else passed++;
            next_cycle();
        end
        clear_in();
        pif.mtvec = 32'h8000_0100;
        @(negedge clk);
        checks++; exp_v = pack(S_ALL, 1'b0, '0, 1'b1, 32'h1000_0010, 5'd7);
        if (obs !== exp_v) $display("[TB] FAIL busy_commit: got %h expected %h", obs, exp_v);
        else passed++;
        next_cycle();
        pif.mtvec = 32'h8000_0200;
        @(negedge clk);
        checks++; exp_v = pack(S_NONE, 1'b1, 32'h8000_0200, 1'b0, '0, '0);
        if (obs !== exp_v) $display("[TB] FAIL busy_redirect: got %h expected %h", obs, exp_v);
        else passed++;
        next_cycle();
        clear_in();
    endtask

    task automatic test_mret_branch();
        pif.mret      = 1'b1;
        pif.mepc      = 32'h8000_1234;
        pif.br_taken  = 1'b1;
        pif.br_target = 32'h0000_0500;
        pif.ld_use    = 1'b1;
        @(negedge clk);
        checks++; exp_v = pack(S_NONE, 1'b1, 32'h8000_1234, 1'b0, '0, '0);
        if (obs !== exp_v) $display("[TB] FAIL mret_over_branch: got %h expected %h", obs, exp_v);
        else passed++;
        next_cycle();
        clear_in();
    endtask

    task automatic test_reset_mid_trap();
        pif.trap       = 1'b1;
        pif.trap_cause = 5'd3;
        pif.trap_pc    = 32'h0000_2000;
        @(negedge clk);
        checks++; exp_v = pack(S_ALL, 1'b0, '0, 1'b0, '0, '0);
        if (obs !== exp_v) $display("[TB] FAIL midreset_entry: got %h expected %h", obs, exp_v);
        else passed++;
        next_cycle();
        clear_in();
        pif.mtvec = 32'h8000_0000;
        rst = 1'b1;
        @(negedge clk);
        checks++; exp_v = pack(S_NONE, 1'b0, '0, 1'b0, '0, '0);
        if (obs !== exp_v) $display("[TB] FAIL midreset_in_commit: got %h expected %h", obs, exp_v);
        else passed++;
        next_cycle();
        rst = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checks++; exp_v = pack(S_NONE, 1'b0, '0, 1'b0, '0, '0);
            if (obs !== exp_v) $display("[TB] FAIL midreset_after_%0d: got %h expected %h", i, obs, exp_v);
            else passed++;
            next_cycle();
        end
        clear_in();
    endtask

`ifdef PIPE_CTRL_PERF_EN
    task automatic test_perf();
        rst = 1'b1;
        clear_in();
        next_cycle();
        rst = 1'b0;
        pif.mdu_busy = 1'b1;
        repeat (10) next_cycle();
        pif.mdu_busy  = 1'b0;
        pif.br_taken  = 1'b1;
        pif.br_target = 32'h0000_0600;
        next_cycle();
        clear_in();
        @(negedge clk);
        checks++;
        if (pif.perf_stall_cnt !== 32'd10)
            $display("[TB] FAIL perf_stall_cnt: got %0d expected 10", pif.perf_stall_cnt);
        else passed++;
        checks++;
        if (pif.perf_flush_cnt !== 32'd1)
            $display("[TB] FAIL perf_flush_cnt: got %0d expected 1", pif.perf_flush_cnt);
        else passed++;
        next_cycle();
    endtask
`endif

    task automatic test_random();
        int commit_t;
        int redir_t;
        int blocked;
        int u;
        logic [PW-1:0] m_epc;
        logic [CW-1:0] m_cause;

        for (int t = 0; t < NRAND; t++) begin
            r_rst[t]   = (t == 0) || ($urandom_range(0, 59) == 0);
            r_trap[t]  = ($urandom_range(0, 7) == 0);
            r_mret[t]  = ($urandom_range(0, 5) == 0);
            r_br[t]    = ($urandom_range(0, 3) == 0);
            r_busy[t]  = ($urandom_range(0, 2) == 0);
            r_ld[t]    = ($urandom_range(0, 3) == 0);
            r_tgt[t]   = $urandom;
            r_mepc[t]  = $urandom;
            r_mtvec[t] = $urandom;
            r_tpc[t]   = $urandom;
            r_cause[t] = CW'($urandom_range(0, 31));
            if (t >= NRAND - 12) begin
                r_trap[t] = 1'b0;
                r_busy[t] = 1'b0;
            end
        end

        // Trap schedule: commit one cycle after the trap (or after the first idle-mdu
        // cycle if the unit was busy), redirect the cycle after that; reset cancels it.
        commit_t = -1;
        redir_t  = -1;
        blocked  = -1;
        m_epc    = '0;
        m_cause  = '0;
        for (int t = 0; t < NRAND; t++) begin
            if (r_rst[t]) begin
                r_exp[t] = pack(S_NONE, 1'b0, '0, 1'b0, '0, '0);
                blocked  = -1;
            end else if (t <= blocked) begin
                if (t == commit_t)     r_exp[t] = pack(S_ALL, 1'b0, '0, 1'b1, m_epc, m_cause);
                else if (t == redir_t) r_exp[t] = pack(S_NONE, 1'b1, r_mtvec[t], 1'b0, '0, '0);
                else                   r_exp[t] = pack(S_ALL, 1'b0, '0, 1'b0, '0, '0);
            end else if (r_trap[t]) begin
                m_epc   = r_tpc[t];
                m_cause = r_cause[t];
                u = t;
                if (r_busy[t]) begin
                    u = t + 1;
                    while (u < NRAND && r_busy[u]) u++;
                end
                commit_t = u + 1;
                redir_t  = commit_t + 1;
                blocked  = redir_t;
                r_exp[t] = pack(S_ALL, 1'b0, '0, 1'b0, '0, '0);
            end else if (r_mret[t]) begin
                r_exp[t] = pack(S_NONE, 1'b1, r_mepc[t], 1'b0, '0, '0);
            end else if (r_br[t]) begin
                r_exp[t] = pack(S_NONE, 1'b1, r_tgt[t], 1'b0, '0, '0);
            end else if (r_busy[t]) begin
                r_exp[t] = pack(S_ALL, 1'b0, '0, 1'b0, '0, '0);
            end else if (r_ld[t]) begin
                r_exp[t] = pack(S_LDUSE, 1'b0, '0, 1'b0, '0, '0);
            end else begin
                r_exp[t] = pack(S_NONE, 1'b0, '0, 1'b0, '0, '0);
            end
        end

        for (int t = 0; t < NRAND; t++) begin
            rst            = r_rst[t];
            pif.trap       = r_trap[t];
            pif.mret       = r_mret[t];
            pif.br_taken   = r_br[t];
            pif.mdu_busy   = r_busy[t];
            pif.ld_use     = r_ld[t];
            pif.br_target  = r_tgt[t];
            pif.mepc       = r_mepc[t];
            pif.mtvec      = r_mtvec[t];
            pif.trap_pc    = r_tpc[t];
            pif.trap_cause = r_cause[t];
            @(negedge clk);
            checks++;
            if (obs !== r_exp[t]) $display("[TB] FAIL random_cycle_%0d: got %h expected %h", t, obs, r_exp[t]);
            else passed++;
            next_cycle();
        end
        rst = 1'b0;
        clear_in();
    endtask

    initial begin
        rst = 1'b1;
        clear_in();
        test_reset();
        test_ld_use();
        test_trap_idle();
        test_trap_busy();
        test_mret_branch();
        test_reset_mid_trap();
`ifdef PIPE_CTRL_PERF_EN
        test_perf();
`endif
        test_random();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
